// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU retire-trace recorder.
package cpu_trace_pkg;

  localparam int PC_W      = 32;
  localparam int INST_W    = 32;
  localparam int RF_ADDR_W = 5;
  localparam int DATA_W    = 32;
  localparam int DM_ADDR_W = 32;

  // Text segment base of the CPU54 memory map; captured PCs are stored relative to it.
  localparam logic [PC_W-1:0] DEFAULT_PC_BASE = 32'h0040_0000;

  // One retired instruction. Field order fixes the packed layout stored in the FIFO.
  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [INST_W-1:0]    inst;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic                 dm_we;
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0]    dm_wdata;
  } trace_rec_t;

  // 32+32+1+5+32+1+32+32 = 167 bits.
  localparam int REC_W = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2
  } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with optional overwrite-oldest on full and a drop pulse
// flagging every record that is lost (refused or evicted).
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_overwrite,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic             o_drop
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_pop;
  logic w_wr_en;
  logic w_evict;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // A pop on an empty FIFO is meaningless and ignored.
  assign w_pop   = i_pop && !o_empty;
  // A write lands when there is room, when a same-cycle pop makes room,
  // or when overwrite mode is allowed to evict the oldest entry.
  assign w_wr_en = i_push && (!o_full || w_pop || i_overwrite);
  assign w_evict = i_push && o_full && !w_pop && i_overwrite;
  assign o_drop  = i_push && o_full && !w_pop;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop || w_evict) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_en && !w_pop && !w_evict) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_wr_en) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // Record storage write port.
  // NOTE: the array has no reset; validity is tracked by r_level alone, so
  // clearing it would only cost flops and block RAM inference.
  always_ff @(posedge clk_in) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  // Head is forced to zero while empty so stale or uninitialised storage never shows.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retire-trace recorder: captures one record per retired instruction into a
// FIFO drained over valid/ready, with start-PC trigger and loss accounting.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int              DEPTH   = 16,
  parameter logic [PC_W-1:0] PC_BASE = DEFAULT_PC_BASE,
  parameter int              CNT_W   = 16,
  parameter int              LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 cfg_en,
  input  logic                 cfg_wrap,
  input  logic                 cfg_trig_en,
  input  logic [PC_W-1:0]      cfg_trig_pc,
  input  logic                 ret_valid,
  input  logic [PC_W-1:0]      ret_pc,
  input  logic [INST_W-1:0]    ret_inst,
  input  logic                 rf_we,
  input  logic [RF_ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0]    rf_wdata,
  input  logic                 dm_we,
  input  logic [DM_ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0]    dm_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [INST_W-1:0]    out_inst,
  output logic                 out_rf_we,
  output logic [RF_ADDR_W-1:0] out_rf_waddr,
  output logic [DATA_W-1:0]    out_rf_wdata,
  output logic                 out_dm_we,
  output logic [DM_ADDR_W-1:0] out_dm_addr,
  output logic [DATA_W-1:0]    out_dm_wdata,
  output logic                 armed,
  output logic [LVL_W-1:0]     level,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     dropped_cnt,
  output logic                 overflow
);

  trace_state_e r_state;
  trace_state_e w_state_nxt;

  logic             w_trig_hit;
  logic             w_push;
  logic             w_pop;
  trace_rec_t       w_rec;
  trace_rec_t       w_head;
  logic [REC_W-1:0] w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_fifo_drop;

  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_dropped_cnt;
  logic             r_overflow;

  assign w_trig_hit = ret_valid && (ret_pc == cfg_trig_pc);

  // The trigger-matching instruction is itself the first captured record.
  assign w_push = ret_valid &&
                  ((r_state == ST_CAPTURE) || ((r_state == ST_WAIT_TRIG) && w_trig_hit));
  assign w_pop  = out_valid && out_ready;

  // Stored PC is relative to PC_BASE; the subtraction wraps modulo 2^32 by design.
  assign w_rec = '{
    pc:       ret_pc - PC_BASE,
    inst:     ret_inst,
    rf_we:    rf_we,
    rf_waddr: rf_waddr,
    rf_wdata: rf_wdata,
    dm_we:    dm_we,
    dm_addr:  dm_addr,
    dm_wdata: dm_wdata
  };

  // State register; reset wins over every other update in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; dropping cfg_en returns to IDLE from anywhere.
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    if (!cfg_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      w_state_nxt = cfg_trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
        ST_WAIT_TRIG: if (w_trig_hit) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE:   w_state_nxt = ST_CAPTURE;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    armed = (r_state == ST_CAPTURE);
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_in      (clk_in),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_overwrite (cfg_wrap),
    .i_data      (w_rec),
    .o_data      (w_fifo_dout),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (level),
    .o_drop      (w_fifo_drop)
  );

  // A lost record can only ever come from a full FIFO.
  a_drop_needs_full: assert property (@(posedge clk_in) disable iff (reset)
    w_fifo_drop |-> w_fifo_full);

  // Saturating retire/drop counters and the sticky overflow flag.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_retired_cnt <= '0;
      r_dropped_cnt <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push && (r_retired_cnt != '1)) r_retired_cnt <= r_retired_cnt + 1'b1;
      if (w_fifo_drop) begin
        if (r_dropped_cnt != '1) r_dropped_cnt <= r_dropped_cnt + 1'b1;
        r_overflow <= 1'b1;
      end
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign dropped_cnt = r_dropped_cnt;
  assign overflow    = r_overflow;

  assign out_valid    = !w_fifo_empty;
  assign w_head       = w_fifo_dout;
  assign out_pc       = w_head.pc;
  assign out_inst     = w_head.inst;
  assign out_rf_we    = w_head.rf_we;
  assign out_rf_waddr = w_head.rf_waddr;
  assign out_rf_wdata = w_head.rf_wdata;
  assign out_dm_we    = w_head.dm_we;
  assign out_dm_addr  = w_head.dm_addr;
  assign out_dm_wdata = w_head.dm_wdata;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=16, PC_BASE=0x00400000).
module tb_cpu_trace_buffer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        cfg_en, cfg_wrap, cfg_trig_en;
  logic [31:0] cfg_trig_pc;
  logic        ret_valid;
  logic [31:0] ret_pc, ret_inst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_rf_wdata;
  logic        out_dm_we;
  logic [31:0] out_dm_addr, out_dm_wdata;
  logic        armed;
  logic [4:0]  level;
  logic [15:0] retired_cnt, dropped_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_trace_buffer dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .cfg_en       (cfg_en),
    .cfg_wrap     (cfg_wrap),
    .cfg_trig_en  (cfg_trig_en),
    .cfg_trig_pc  (cfg_trig_pc),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .ret_inst     (ret_inst),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_rf_we    (out_rf_we),
    .out_rf_waddr (out_rf_waddr),
    .out_rf_wdata (out_rf_wdata),
    .out_dm_we    (out_dm_we),
    .out_dm_addr  (out_dm_addr),
    .out_dm_wdata (out_dm_wdata),
    .armed        (armed),
    .level        (level),
    .retired_cnt  (retired_cnt),
    .dropped_cnt  (dropped_cnt),
    .overflow     (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One retire whose side-band fields are derived from the PC.
  task automatic retire(input logic [31:0] pc);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_inst  = {16'hC0DE, pc[15:0]};
    rf_we     = 1'b1;
    rf_waddr  = pc[6:2];
    rf_wdata  = ~pc;
    dm_we     = pc[2];
    dm_addr   = pc + 32'h0000_1000;
    dm_wdata  = pc ^ 32'h5A5A_5A5A;
    step();
    ret_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_en = 1'b0; cfg_wrap = 1'b0; cfg_trig_en = 1'b0;
    cfg_trig_pc = '0; ret_valid = 1'b0; ret_pc = '0; ret_inst = '0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_armed", armed, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_dropped", dropped_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);

    // Free-run capture
    cfg_en = 1'b1;
    step();
    check("fr_armed", armed, 1);
    retire(32'h0040_0000);
    check("fr_latency_valid", out_valid, 1);
    retire(32'h0040_0004);
    retire(32'h0040_0008);
    check("fr_level", level, 3);
    check("fr_head_pc", out_pc, 32'h0);
    check("fr_head_inst", out_inst, 32'hC0DE_0000);
    check("fr_head_rf_we", out_rf_we, 1);
    check("fr_head_rf_waddr", out_rf_waddr, 0);
    check("fr_head_rf_wdata", out_rf_wdata, 32'hFFBF_FFFF);
    check("fr_head_dm_we", out_dm_we, 0);
    check("fr_head_dm_addr", out_dm_addr, 32'h0040_1000);
    check("fr_head_dm_wdata", out_dm_wdata, 32'h5A1A_5A5A);
    out_ready = 1'b1;
    step();
    check("fr_drain_pc1", out_pc, 32'h4);
    check("fr_drain_rf_waddr1", out_rf_waddr, 1);
    check("fr_drain_dm_we1", out_dm_we, 1);
    step();
    check("fr_drain_pc2", out_pc, 32'h8);
    step();
    check("fr_drain_empty", out_valid, 0);
    check("fr_drain_level", level, 0);
    // Push into an empty FIFO while out_ready is high: record must land.
    retire(32'h0040_0100);
    check("empty_push_level", level, 1);
    check("empty_push_pc", out_pc, 32'h100);
    step();
    check("empty_pop_level", level, 0);
    out_ready = 1'b0;
    // PC below the base wraps modulo 2^32.
    retire(32'h0000_0010);
    check("pc_wrap", out_pc, 32'hFFC0_0010);

    // Stop-on-full
    cfg_wrap = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 20; i++) retire(32'h0040_0000 + 32'(4 * i));
    check("stop_level", level, 16);
    check("stop_retired", retired_cnt, 20);
    check("stop_dropped", dropped_cnt, 4);
    check("stop_overflow", overflow, 1);
    check("stop_head_pc", out_pc, 32'h0);
    // Full with simultaneous push and pop.
    out_ready = 1'b1;
    retire(32'h0040_0200);
    out_ready = 1'b0;
    check("stop_pp_level", level, 16);
    check("stop_pp_dropped", dropped_cnt, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stop_drain_%0d", i), out_pc, (i < 15) ? 32'(4 * (i + 1)) : 32'h200);
      step();
    end
    out_ready = 1'b0;
    check("stop_drain_empty", out_valid, 0);

    // Overwrite-oldest
    cfg_wrap = 1'b1;
    do_reset();
    step();
    for (int i = 0; i < 20; i++) retire(32'h0040_0000 + 32'(4 * i));
    check("wrap_level", level, 16);
    check("wrap_dropped", dropped_cnt, 4);
    check("wrap_overflow", overflow, 1);
    check("wrap_head_pc", out_pc, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap_drain_%0d", i), out_pc, 32'h10 + 32'(4 * i));
      step();
    end
    out_ready = 1'b0;
    check("wrap_drain_empty", out_valid, 0);

    // Trigger
    cfg_wrap    = 1'b0;
    cfg_trig_en = 1'b1;
    cfg_trig_pc = 32'h0040_000C;
    do_reset();
    step();
    check("trig_wait_armed", armed, 0);
    for (int i = 0; i < 6; i++) begin
      retire(32'h0040_0000 + 32'(4 * i));
      check($sformatf("trig_armed_%0d", i), armed, (i >= 3) ? 32'd1 : 32'd0);
    end
    check("trig_level", level, 3);
    check("trig_head_pc", out_pc, 32'hC);
    check("trig_retired", retired_cnt, 3);
    // Disabling returns to IDLE; contents kept, retires ignored.
    cfg_en = 1'b0;
    step();
    check("idle_armed", armed, 0);
    retire(32'h0040_0020);
    check("idle_level", level, 3);
    check("idle_head_pc", out_pc, 32'hC);

    // Reset mid-capture at level 5 with two drops
    cfg_en      = 1'b1;
    cfg_trig_en = 1'b0;
    cfg_wrap    = 1'b1;
    do_reset();
    step();
    for (int i = 0; i < 18; i++) retire(32'h0040_0000 + 32'(4 * i));
    drain(11);
    check("mid_pre_level", level, 5);
    check("mid_pre_dropped", dropped_cnt, 2);
    reset = 1'b1;
    retire(32'h0040_0300);
    reset  = 1'b0;
    cfg_en = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_level", level, 0);
    check("mid_retired", retired_cnt, 0);
    check("mid_dropped", dropped_cnt, 0);
    check("mid_overflow", overflow, 0);
    check("mid_armed", armed, 0);
    check("mid_out_pc", out_pc, 0);
    step();
    check("mid_post_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable retire-trace recorder for the single-cycle/multi-cycle CPU54 core (sccomp_dataflow level).
- Captures one record per retired instruction: PC, instruction, register-file write and data-memory write. Records go into a parametrised on-chip FIFO, drained through a valid/ready port.
- Adds start-PC triggering, stop-on-full or overwrite-oldest modes, and retired/dropped counters. Traces can therefore be collected on FPGA or in long simulations without a file dump.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- PC_BASE, 32'h00400000: subtracted from every captured PC.
- CNT_W, 16: width of the retired and dropped counters.
- LVL_W, $clog2(DEPTH)+1: width of the level output (derived; do not override).

Ports:
- clk_in  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_en  in  1  capture enable.
- cfg_wrap  in  1  full-FIFO mode: 0 = stop (drop new records), 1 = overwrite oldest record.
- cfg_trig_en  in  1  1 = hold off capture until a PC match.
- cfg_trig_pc  in  32  trigger PC (absolute, not offset).
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  32  PC of the retiring instruction.
- ret_inst  in  32  instruction word.
- rf_we  in  1  register-file write by the retiring instruction.
- rf_waddr  in  5  register-file write address.
- rf_wdata  in  32  register-file write data.
- dm_we  in  1  data-memory write by the retiring instruction.
- dm_addr  in  32  data-memory address.
- dm_wdata  in  32  data-memory write data.
- out_valid  out  1  head record is available.
- out_ready  in  1  consumer accepts the head record.
- out_pc  out  32  head record PC, equal to ret_pc - PC_BASE.
- out_inst, out_rf_we, out_rf_waddr, out_rf_wdata, out_dm_we, out_dm_addr, out_dm_wdata  out  32/1/5/32/1/32/32  remaining head record fields.
- armed  out  1  1 while in the CAPTURE state.
- level  out  LVL_W  current FIFO occupancy.
- retired_cnt  out  CNT_W  number of retires seen in CAPTURE.
- dropped_cnt  out  CNT_W  number of records lost (dropped or overwritten).
- overflow  out  1  sticky: at least one record lost since reset.

Behaviour:
- Reset, sampled on a clk_in edge with reset=1:
  - state goes to IDLE; FIFO is flushed;
  - out_valid=0, level=0, armed=0, both counters=0, overflow=0;
  - out_* data fields are 0.
  - Reset asserted mid-capture discards all content; the reset edge has priority over any push or pop in the same cycle.
- State machine, states IDLE, WAIT_TRIG, CAPTURE:
  - IDLE -> CAPTURE when cfg_en=1 and cfg_trig_en=0.
  - IDLE -> WAIT_TRIG when cfg_en=1 and cfg_trig_en=1.
  - WAIT_TRIG -> CAPTURE on ret_valid && ret_pc==cfg_trig_pc. The matching record itself is captured in that same cycle.
  - Any state -> IDLE when cfg_en=0. FIFO contents are retained and remain drainable in IDLE.
  - CAPTURE -> WAIT_TRIG never happens; re-arming requires cfg_en to go low, then high.
- Push condition: ret_valid=1 and the block is in CAPTURE, or in WAIT_TRIG with a trigger match that cycle.
  - rf_* and dm_* are sampled in the same cycle as ret_valid and ignored when ret_valid=0.
  - Stored PC is ret_pc - PC_BASE, modulo 2^32 (wraps, no error).
- Counters:
  - retired_cnt increments on every push attempt, whether accepted or dropped.
  - retired_cnt and dropped_cnt saturate at all-ones.
- Pop condition: out_valid && out_ready.
- Output timing:
  - out_* present the head entry; out_valid = (level != 0).
  - A record pushed at edge N is visible at out_* after edge N (one-cycle latency) when the FIFO was empty.
- Full FIFO, stop mode (cfg_wrap=0):
  - push without pop: record dropped; dropped_cnt+1; overflow<=1; level stays DEPTH.
  - push with pop in the same cycle: push accepted; level unchanged; dropped_cnt unchanged.
- Full FIFO, wrap mode (cfg_wrap=1):
  - push without pop: oldest record discarded, new record written; both pointers advance; dropped_cnt+1; overflow<=1; level stays DEPTH.
  - push with pop: normal push and pop, no drop.
- Empty FIFO: out_ready is ignored; a same-cycle push lands and appears after the edge.
- Pointers are log2(DEPTH) bits and wrap naturally.
- cfg_wrap and cfg_trig_pc may change at any time and take effect on the next edge.

Decomposition:
- Package cpu_trace_pkg holds:
  - record field widths and the packed record width (32+32+1+5+32+1+32+32 = 167);
  - the state encoding (IDLE, WAIT_TRIG, CAPTURE);
  - the default PC_BASE constant.
- Sub-module trace_fifo: synchronous FIFO parametrised on WIDTH and DEPTH. It provides:
  - an overwrite input;
  - full, empty and level outputs;
  - a drop pulse.
- The top level contains the state machine, PC offsetting, counters and the overflow flag.

Test Plan:
- Free-run capture: reset, cfg_en=1, cfg_trig_en=0; retire PCs 0x00400000, 0x00400004, 0x00400008 on consecutive cycles, out_ready=0 -> level=3, out_pc=0x0. With out_ready=1 the drain yields out_pc 0x0, 0x4, 0x8 in order, then out_valid=0.
- Stop-on-full: DEPTH=16, cfg_wrap=0, 20 consecutive retires, out_ready=0 -> level=16, retired_cnt=20, dropped_cnt=4, overflow=1, head out_pc=0x0.
- Overwrite-oldest: same stimulus with cfg_wrap=1 -> level=16, dropped_cnt=4, head out_pc=0x10. The drain ends with out_pc=0x4C.
- Trigger: cfg_trig_en=1, cfg_trig_pc=0x0040000C; retire PCs 0x00400000 through 0x00400014 -> armed rises after the 0x0040000C edge, level=3, first out_pc=0xC, retired_cnt=3.
- Full with simultaneous push/pop, stop mode: with level=16, assert ret_valid and out_ready together -> level stays 16, dropped_cnt unchanged, new record appears at the tail.
- Reset mid-capture at level=5 with dropped_cnt=2 -> after the reset edge: out_valid=0, level=0, both counters=0, overflow=0, armed=0. A retire in that same cycle is not recorded.
